// File: rtl/dm_store_buffer.sv
// ----------------------------------------------------------------------------
// dm_store_buffer
//   Posted-write store buffer sitting between the processor MEM-stage bus and
//   a single-port data memory. Stores are queued in a circular FIFO and drained
//   to memory on any cycle the processor is not loading. Loads go to memory in
//   the same cycle; if a buffered store matches the load's word address, the
//   youngest matching entry supplies the data instead of memory.
//
//   Optional feature macro: SB_COALESCE_EN
//     When defined, a store to the same word as the youngest entry overwrites
//     that entry's data in place instead of allocating a new entry.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   MEM_mem_cmd  in   processor bus command (BUS_NONE / BUS_LOAD / BUS_STORE)
//   MEM_mem_addr in   processor byte address (word aligned)
//   MEM_mem_din  in   processor store data
//   DM_mem_dout  out  load data to processor (combinational, forwarded on hit)
//   SB_full      out  store refused this cycle; processor must hold it
//   SB_empty     out  buffer holds no entries
//   sb_mem_cmd   out  command to memory
//   sb_mem_addr  out  address to memory
//   sb_mem_din   out  write data to memory
//   mem_dout     in   memory read data (combinational)
//   mem_ready    in   memory accepts a presented store this cycle
// ----------------------------------------------------------------------------
`ifndef BUS_NONE
`define BUS_NONE  2'b00
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'b01
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'b10
`endif

module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    MEM_mem_cmd,
    input  logic [AW-1:0] MEM_mem_addr,
    input  logic [31:0]   MEM_mem_din,
    output logic [31:0]   DM_mem_dout,
    output logic          SB_full,
    output logic          SB_empty,
    output logic [1:0]    sb_mem_cmd,
    output logic [AW-1:0] sb_mem_addr,
    output logic [31:0]   sb_mem_din,
    input  logic [31:0]   mem_dout,
    input  logic          mem_ready
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          WW      = AW - 2;
    localparam logic [PW:0] L_DEPTH = (PW+1)'(DEPTH);

    logic [WW-1:0]    r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;

    logic [WW-1:0] w_waddr;
    logic          w_is_load;
    logic          w_is_store;
    logic          w_drain;
    logic          w_coal;
    logic          w_enq;
    logic [31:0]   w_fwd;
    logic          w_unused;

    assign w_waddr    = MEM_mem_addr[AW-1:2];
    assign w_is_load  = (MEM_mem_cmd == `BUS_LOAD);
    assign w_is_store = (MEM_mem_cmd == `BUS_STORE);
    // byte-offset bits are always zero for word-aligned traffic
    assign w_unused   = &{1'b0, MEM_mem_addr[1:0]};

    // Memory port arbitration: loads always win; otherwise present the head.
    always_comb begin
        sb_mem_cmd  = `BUS_NONE;
        sb_mem_addr = '0;
        sb_mem_din  = '0;
        if (w_is_load) begin
            sb_mem_cmd  = `BUS_LOAD;
            sb_mem_addr = MEM_mem_addr;
        end else if (r_count != '0) begin
            sb_mem_cmd  = `BUS_STORE;
            sb_mem_addr = {r_addr[r_head], 2'b00};
            sb_mem_din  = r_data[r_head];
        end
    end

    assign w_drain = (sb_mem_cmd == `BUS_STORE) && mem_ready;

    // Forwarding: walk entries oldest to youngest so the youngest hit wins.
    // Valid entries are contiguous from head, so the walk order is age order.
    always_comb begin
        w_fwd = mem_dout;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[r_head + PW'(i)] && (r_addr[r_head + PW'(i)] == w_waddr))
                w_fwd = r_data[r_head + PW'(i)];
        end
    end

    assign DM_mem_dout = w_fwd;

`ifdef SB_COALESCE_EN
    logic [PW-1:0] w_last;
    assign w_last = r_tail - PW'(1);
    // Merge into the youngest entry unless that entry is leaving this cycle.
    assign w_coal = w_is_store && r_vld[w_last] && (r_addr[w_last] == w_waddr) &&
                    !((w_last == r_head) && w_drain);
`else
    assign w_coal = 1'b0;
`endif

    assign w_enq    = w_is_store && !w_coal && ((r_count != L_DEPTH) || w_drain);
    assign SB_full  = w_is_store && (r_count == L_DEPTH) && !w_drain && !w_coal;
    assign SB_empty = (r_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_drain) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PW'(1);
            end
            // Placed after the drain so a full-buffer drain+enqueue to the
            // same slot leaves it valid.
            if (w_enq) begin
                r_addr[r_tail] <= w_waddr;
                r_data[r_tail] <= MEM_mem_din;
                r_vld[r_tail]  <= 1'b1;
                r_tail         <= r_tail + PW'(1);
            end
`ifdef SB_COALESCE_EN
            if (w_coal)
                r_data[w_last] <= MEM_mem_din;
`endif
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
`ifndef BUS_NONE
`define BUS_NONE  2'b00
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'b01
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'b10
`endif

module tb_dm_store_buffer;

    localparam int DEPTH = 4;
`ifdef SB_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk, rst;
    logic [1:0]  cmd;
    logic [31:0] addr, din, mdout;
    logic        rdy;
    logic [31:0] DM_mem_dout, sb_mem_addr, sb_mem_din;
    logic        SB_full, SB_empty;
    logic [1:0]  sb_mem_cmd;

    dm_store_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .MEM_mem_cmd(cmd), .MEM_mem_addr(addr), .MEM_mem_din(din),
        .DM_mem_dout(DM_mem_dout), .SB_full(SB_full), .SB_empty(SB_empty),
        .sb_mem_cmd(sb_mem_cmd), .sb_mem_addr(sb_mem_addr), .sb_mem_din(sb_mem_din),
        .mem_dout(mdout), .mem_ready(rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [29:0] wa;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   m_drain, m_coal, m_enq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive after negedge, check combinational outputs against
    // the queue model, then commit the model at the rising edge.
    task automatic cyc(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] md, input logic r);
        logic [1:0]  e_cmd;
        logic [31:0] e_addr, e_din, e_dout;
        logic        e_full;
        int          sz;
        ent_t        t;
        @(negedge clk);
        cmd = c; addr = a; din = d; mdout = md; rdy = r;
        #1;
        sz = q.size();
        e_cmd = `BUS_NONE; e_addr = 0; e_din = 0;
        if (c == `BUS_LOAD) begin
            e_cmd = `BUS_LOAD; e_addr = a;
        end else if (sz > 0) begin
            e_cmd = `BUS_STORE; e_addr = {q[0].wa, 2'b00}; e_din = q[0].d;
        end
        e_dout = md;
        for (int k = 0; k < sz; k++)
            if (q[k].wa == a[31:2]) e_dout = q[k].d;
        m_drain = (e_cmd == `BUS_STORE) && r;
        m_coal  = COAL && (c == `BUS_STORE) && (sz > 0) && (q[sz-1].wa == a[31:2]) &&
                  !(sz == 1 && m_drain);
        e_full  = (c == `BUS_STORE) && (sz == DEPTH) && !m_drain && !m_coal;
        m_enq   = (c == `BUS_STORE) && !m_coal && !e_full;
        chk("cmd",   {30'b0, sb_mem_cmd}, {30'b0, e_cmd});
        chk("addr",  sb_mem_addr, e_addr);
        if (c != `BUS_LOAD) chk("din", sb_mem_din, e_din);
        if (c == `BUS_LOAD) chk("dout", DM_mem_dout, e_dout);
        chk("full",  {31'b0, SB_full},  {31'b0, e_full});
        chk("empty", {31'b0, SB_empty}, {31'b0, (sz == 0)});
        @(posedge clk);
        if (m_coal) begin
            t = q[sz-1]; t.d = d; q[sz-1] = t;
        end
        if (m_drain) void'(q.pop_front());
        if (m_enq) q.push_back({a[31:2], d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with a store presented
        rst = 1'b0; cmd = `BUS_STORE; addr = 32'h100; din = 32'h1234; mdout = 32'h55; rdy = 1'b1;
        #2;
        chk("rst_empty", {31'b0, SB_empty}, 32'd1);
        chk("rst_full",  {31'b0, SB_full},  32'd0);
        chk("rst_cmd",   {30'b0, sb_mem_cmd}, {30'b0, `BUS_NONE});
        chk("rst_addr",  sb_mem_addr, 32'h0);
        chk("rst_din",   sb_mem_din, 32'h0);
        chk("rst_dout",  DM_mem_dout, 32'h55);
        @(negedge clk);
        cmd = `BUS_NONE;
        rst = 1'b1;
        cyc(`BUS_NONE, 0, 0, 0, 1'b1);          // nothing was enqueued

        // store then forwarded load, then drain
        cyc(`BUS_STORE, 32'h100, 32'hDEADBEEF, 0, 1'b1);
        cyc(`BUS_LOAD,  32'h100, 0, 32'h0, 1'b1);
        cyc(`BUS_NONE,  0, 0, 0, 1'b1);
        cyc(`BUS_NONE,  0, 0, 0, 1'b1);

        // same-word stores, youngest forwards
        cyc(`BUS_STORE, 32'h40, 32'h1, 0, 1'b0);
        cyc(`BUS_STORE, 32'h40, 32'h2, 0, 1'b0);
        cyc(`BUS_LOAD,  32'h40, 0, 32'hFFFF, 1'b0);
        for (int i = 0; i < 3; i++) cyc(`BUS_NONE, 0, 0, 0, 1'b1);

        // fill, refuse, then drain+accept same cycle
        for (int i = 0; i < 4; i++) cyc(`BUS_STORE, 32'(i*4), 32'hA0 + 32'(i), 0, 1'b0);
        cyc(`BUS_STORE, 32'h10, 32'hB0, 0, 1'b0);
        cyc(`BUS_STORE, 32'h10, 32'hB0, 0, 1'b0);
        cyc(`BUS_STORE, 32'h10, 32'hB0, 0, 1'b1);
        cyc(`BUS_LOAD,  32'h10, 0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(`BUS_NONE, 0, 0, 0, 1'b1);

        // loads starve the drain
        cyc(`BUS_STORE, 32'h200, 32'hC1, 0, 1'b0);
        cyc(`BUS_STORE, 32'h204, 32'hC2, 0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(`BUS_LOAD, 32'h300, 0, 32'h77 + 32'(i), 1'b1);
        for (int i = 0; i < 3; i++) cyc(`BUS_NONE, 0, 0, 0, 1'b1);

        // reset mid-operation
        for (int i = 0; i < 3; i++) cyc(`BUS_STORE, 32'h400 + 32'(i*4), 32'hD0 + 32'(i), 0, 1'b0);
        @(negedge clk);
        cmd = `BUS_NONE; rdy = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_empty", {31'b0, SB_empty}, 32'd1);
        chk("mid_rst_cmd",   {30'b0, sb_mem_cmd}, {30'b0, `BUS_NONE});
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(`BUS_NONE, 0, 0, 0, 1'b1);

        // randomized traffic over a small address window to exercise hits
        for (int i = 0; i < 600; i++) begin
            logic [1:0] c;
            case ($urandom_range(0, 2))
                0:       c = `BUS_NONE;
                1:       c = `BUS_LOAD;
                default: c = `BUS_STORE;
            endcase
            cyc(c, {27'b0, 3'($urandom_range(0, 7)), 2'b00}, $urandom, $urandom,
                1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-write store buffer between the processor MEM stage bus and the single-port data memory.
- Stores are queued in a FIFO and drained to memory on cycles the processor is not loading.
- Loads go straight to memory in the same cycle; the youngest matching buffered store forwards its data instead.
- Lets the memory delay write acceptance (mem_ready) without stalling every store.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, >= 2.
- AW, 32, address width; word address = addr[AW-1:2].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MEM_mem_cmd  in  2  processor bus command: `BUS_NONE, `BUS_LOAD or `BUS_STORE.
- MEM_mem_addr  in  AW  processor byte address, word-aligned.
- MEM_mem_din  in  32  processor store data.
- DM_mem_dout  out  32  load data returned to the processor, combinational.
- SB_full  out  1  store not accepted this cycle; processor must hold the store.
- SB_empty  out  1  buffer holds no entries.
- sb_mem_cmd  out  2  command to memory.
- sb_mem_addr  out  AW  address to memory.
- sb_mem_din  out  32  write data to memory.
- mem_dout  in  32  memory read data, combinational.
- mem_ready  in  1  memory accepts a presented store this cycle.

Behaviour:
- Storage:
  - Circular FIFO of {word addr, data}.
  - Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Reset (rst=0, async):
  - head=tail=count=0; all entries invalid.
  - Outputs: sb_mem_cmd=`BUS_NONE, SB_empty=1, SB_full=0, sb_mem_addr=0, sb_mem_din=0, DM_mem_dout=mem_dout.
- Port arbitration (combinational, each cycle):
  - MEM_mem_cmd=`BUS_LOAD: sb_mem_cmd=`BUS_LOAD, sb_mem_addr=MEM_mem_addr. No drain.
  - Otherwise, count>0: sb_mem_cmd=`BUS_STORE, address and data taken from the head entry.
  - Otherwise: sb_mem_cmd=`BUS_NONE, sb_mem_addr=0, sb_mem_din=0.
- drain = (sb_mem_cmd==`BUS_STORE) && mem_ready. The head pops at the clock edge.
- Load forwarding:
  - Compare MEM_mem_addr[AW-1:2] against all valid entries.
  - On a hit, DM_mem_dout = data of the youngest matching entry (closest to tail). On a miss, DM_mem_dout = mem_dout.
  - Zero added latency.
- Store enqueue: MEM_mem_cmd=`BUS_STORE, and either count<DEPTH or drain this cycle.
  - Writes the entry at tail; tail increments.
  - SB_full = (MEM_mem_cmd==`BUS_STORE) && count==DEPTH && !drain. A refused store leaves all state unchanged.
- count update per edge: +1 on enqueue only, -1 on drain only, unchanged when both or neither occur.
- A store enqueued in cycle N is drainable no earlier than cycle N+1; there is no bypass to the memory port.
- A load never drains. Continuous loads starve the drain indefinitely, by design.
- SB_empty = (count==0), registered-state derived.
- Reset mid-operation discards pending entries; no partial store is issued.

Optional Feature:
- Macro SB_COALESCE_EN.
- Defined: a store whose word address equals the youngest entry (tail-1) overwrites that entry's data instead of allocating.
  - Exception: if that entry is also the head and drains this cycle, a normal enqueue occurs.
  - A coalesced store is accepted even when count==DEPTH; SB_full=0 in that case.
  - count and tail are unchanged on a coalesce.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset: hold rst=0 with MEM_mem_cmd=`BUS_STORE -> SB_empty=1, SB_full=0, sb_mem_cmd=`BUS_NONE; nothing enqueued.
- Store 0x100/0xDEADBEEF, next cycle load 0x100 with mem_dout=0x0 -> DM_mem_dout=0xDEADBEEF, sb_mem_cmd=`BUS_LOAD. Next idle cycle with mem_ready=1 -> `BUS_STORE to 0x100, data 0xDEADBEEF; SB_empty=1 after.
- Stores 0x40/0x1 then 0x40/0x2 with mem_ready=0, then load 0x40 -> DM_mem_dout=0x2. Resulting count: 2 without SB_COALESCE_EN, 1 with it.
- mem_ready=0, four stores to 0x0, 0x4, 0x8, 0xC; fifth store 0x10 -> SB_full=1, count stays 4. Raise mem_ready with the store held -> 0x0 drains, 0x10 accepted in the same cycle, count=4.
- Back-to-back loads for 5 cycles with 2 entries pending and mem_ready=1 -> no `BUS_STORE issued, count=2. First `BUS_NONE cycle drains entries in FIFO order.
- Three entries pending, assert rst=0 mid-cycle -> count=0 and sb_mem_cmd=`BUS_NONE immediately; after release, idle cycles issue no stores.
